// File: rtl/sm_state_memory_timed.sv
// sm_state_memory_timed
// Parametrised FSM state memory: registers the next state on every enabled
// clock, tracks the previous state, counts dwell cycles in the current state,
// forces a return to IDLE_STATE on dwell timeout and traps illegal next-state
// codes (NS > MAX_STATE) into IDLE_STATE with a sticky error flag.

module sm_state_memory_timed #(
    parameter int W              = 4,
    parameter int RST_STATE      = 0,
    parameter int IDLE_STATE     = 0,
    parameter int MAX_STATE      = 9,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [W-1:0]  NS,
    input  logic          TO_EN,
    output logic [W-1:0]  CS,
    output logic [W-1:0]  PS,
    output logic [DW-1:0] DWELL,
    output logic          CHG,
    output logic          TO,
    output logic          ERR
);

    // ------------------------------------------------------------------
    // Configuration checks, rejected at elaboration time
    // ------------------------------------------------------------------
    generate
        if (W < 1 || W > 31) begin : g_bad_width
            $error("sm_state_memory_timed: W must be in 1..31");
        end
        if (DW < 1 || DW > 32) begin : g_bad_dw
            $error("sm_state_memory_timed: DW must be in 1..32");
        end
        if (RST_STATE > MAX_STATE || RST_STATE < 0) begin : g_bad_rst_state
            $error("sm_state_memory_timed: RST_STATE must not exceed MAX_STATE");
        end
        if (TIMEOUT_CYCLES < 0 || 64'(TIMEOUT_CYCLES) > (64'd1 << DW)) begin : g_bad_timeout
            $error("sm_state_memory_timed: TIMEOUT_CYCLES must be in 0..2**DW");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants sized to the datapath
    // ------------------------------------------------------------------
    localparam logic [W-1:0]  RST_V     = W'(RST_STATE);
    localparam logic [W-1:0]  IDLE_V    = W'(IDLE_STATE);
    localparam logic [31:0]   MAX_U     = 32'(MAX_STATE);
    localparam bit            TO_ON     = (TIMEOUT_CYCLES != 0);
    // Last dwell value before expiry; only meaningful when TO_ON is set.
    localparam logic [DW-1:0] TO_LIMIT  = TO_ON ? DW'(TIMEOUT_CYCLES - 1) : '1;
    localparam logic [DW-1:0] DWELL_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  cs_reg,    cs_next;
    logic [W-1:0]  ps_reg,    ps_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          chg_reg,   chg_next;
    logic          to_reg,    to_next;
    logic          err_reg,   err_next;

    logic          ns_illegal;
    logic          timeout_hit;

    // The compare is >= rather than == so that a timeout held off by TO_EN=0
    // fires on the first enabled edge after TO_EN is raised again.
    assign ns_illegal  = (32'(NS) > MAX_U);
    assign timeout_hit = TO_ON && TO_EN && (cs_reg != IDLE_V) && (dwell_reg >= TO_LIMIT);

    // Next-state selection; rules are ordered by priority, first match wins
    always_comb begin
        cs_next    = cs_reg;
        ps_next    = ps_reg;
        dwell_next = dwell_reg;
        chg_next   = 1'b0;
        to_next    = 1'b0;
        err_next   = err_reg;

        if (!EN) begin
            // Freeze: hold all state, pulses drop
            cs_next = cs_reg;
        end else if (ns_illegal) begin
            // Trap illegal code into idle; no change pulse if already idle
            err_next   = 1'b1;
            dwell_next = '0;
            cs_next    = IDLE_V;
            if (cs_reg != IDLE_V) begin
                ps_next  = cs_reg;
                chg_next = 1'b1;
            end
        end else if (timeout_hit) begin
            // Dwell expired outside idle: abandon and return to idle
            cs_next    = IDLE_V;
            ps_next    = cs_reg;
            dwell_next = '0;
            chg_next   = 1'b1;
            to_next    = 1'b1;
        end else if (NS != cs_reg) begin
            // Ordinary transition
            cs_next    = NS;
            ps_next    = cs_reg;
            dwell_next = '0;
            chg_next   = 1'b1;
        end else begin
            // Staying put: count dwell, saturating at all-ones
            if (dwell_reg != DWELL_MAX) begin
                dwell_next = dwell_reg + 1'b1;
            end
        end
    end

    // Register update with synchronous reset taking priority over EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_reg    <= RST_V;
            ps_reg    <= RST_V;
            dwell_reg <= '0;
            chg_reg   <= 1'b0;
            to_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            cs_reg    <= cs_next;
            ps_reg    <= ps_next;
            dwell_reg <= dwell_next;
            chg_reg   <= chg_next;
            to_reg    <= to_next;
            err_reg   <= err_next;
        end
    end

    assign CS    = cs_reg;
    assign PS    = ps_reg;
    assign DWELL = dwell_reg;
    assign CHG   = chg_reg;
    assign TO    = to_reg;
    assign ERR   = err_reg;

endmodule

// File: tb/tb_sm_state_memory_timed.sv
// Self-checking bench for sm_state_memory_timed. A driver applies directed
// and random stimulus on the falling edge and pushes the reference model's
// predicted outputs into a queue; a monitor pops and compares after each
// rising edge.

module tb_sm_state_memory_timed;

    localparam int W          = 4;
    localparam int RST_STATE  = 1;
    localparam int IDLE_STATE = 0;
    localparam int MAX_STATE  = 9;
    localparam int DW         = 4;
    localparam int TIMEOUT    = 8;
    localparam int DW_SAT     = (1 << DW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [W-1:0]  ns;
    logic          to_en;
    logic [W-1:0]  cs;
    logic [W-1:0]  ps;
    logic [DW-1:0] dwell;
    logic          chg;
    logic          to;
    logic          err;

    sm_state_memory_timed #(
        .W              (W),
        .RST_STATE      (RST_STATE),
        .IDLE_STATE     (IDLE_STATE),
        .MAX_STATE      (MAX_STATE),
        .DW             (DW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en),
        .NS    (ns),
        .TO_EN (to_en),
        .CS    (cs),
        .PS    (ps),
        .DWELL (dwell),
        .CHG   (chg),
        .TO    (to),
        .ERR   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    id;
        string tag;
        int    cs;
        int    ps;
        int    dw;
        bit    chg;
        bit    to;
        bit    err;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int txn_id      = 0;
    bit drive_done  = 0;

    // Reference model state: plain integers
    int  m_cs, m_ps, m_dw;
    bit  m_err;

    // Apply one cycle of stimulus and predict the outcome of the next edge
    task automatic step(input bit r, input bit e, input int n, input bit te, input string tag);
        exp_t x;
        bit   c, t;
        @(negedge clk);
        rst   = r;
        en    = e;
        ns    = W'(n);
        to_en = te;
        c = 0;
        t = 0;
        if (r) begin
            m_cs = RST_STATE; m_ps = RST_STATE; m_dw = 0; m_err = 0;
        end else if (!e) begin
            // nothing moves
        end else if (n > MAX_STATE) begin
            m_err = 1;
            m_dw  = 0;
            if (m_cs != IDLE_STATE) begin
                m_ps = m_cs; m_cs = IDLE_STATE; c = 1;
            end
        end else if (te && TIMEOUT != 0 && m_cs != IDLE_STATE && m_dw + 1 >= TIMEOUT) begin
            m_ps = m_cs; m_cs = IDLE_STATE; m_dw = 0; c = 1; t = 1;
        end else if (n != m_cs) begin
            m_ps = m_cs; m_cs = n; m_dw = 0; c = 1;
        end else begin
            m_dw = (m_dw < DW_SAT) ? m_dw + 1 : DW_SAT;
        end
        x.id = txn_id; x.tag = tag;
        x.cs = m_cs; x.ps = m_ps; x.dw = m_dw;
        x.chg = c; x.to = t; x.err = m_err;
        txn_id++;
        exp_q.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the oldest pending prediction
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (int'(cs) != x.cs || int'(ps) != x.ps || int'(dwell) != x.dw ||
                    chg !== x.chg || to !== x.to || err !== x.err) begin
                    miscompares++;
                    $display("FAIL txn %0d [%s]: got cs=%0d ps=%0d dwell=%0d chg=%b to=%b err=%b, want cs=%0d ps=%0d dwell=%0d chg=%b to=%b err=%b",
                             x.id, x.tag, cs, ps, dwell, chg, to, err,
                             x.cs, x.ps, x.dw, x.chg, x.to, x.err);
                end else begin
                    $display("txn %0d [%s]: cs=%0d ps=%0d dwell=%0d chg=%b to=%b err=%b ok",
                             x.id, x.tag, cs, ps, dwell, chg, to, err);
                end
            end
        end
    end

    // Stimulus: directed scenarios then constrained-random traffic
    initial begin
        int n;
        bit r, e, te;
        rst = 1'b1; en = 1'b0; ns = '0; to_en = 1'b0;
        m_cs = RST_STATE; m_ps = RST_STATE; m_dw = 0; m_err = 0;

        // Reset and first load
        step(1, 0, 0, 1, "reset");
        step(1, 1, 7, 1, "reset");
        step(0, 1, 3, 1, "load");
        for (int i = 0; i < 5; i++) step(0, 1, 3, 1, "hold");

        // Enable freeze with a pending different NS
        for (int i = 0; i < 10; i++) step(0, 0, 7, 1, "freeze");
        step(0, 1, 7, 1, "unfreeze");

        // Timeout: 8th edge after entry returns to idle
        step(0, 1, 5, 1, "enter5");
        for (int i = 0; i < 8; i++) step(0, 1, 5, 1, "timeout");
        step(0, 1, 0, 1, "after_to");

        // Timeout suppressed, counter saturates, then fires when re-enabled
        step(0, 1, 5, 0, "enter5");
        for (int i = 0; i < 20; i++) step(0, 1, 5, 0, "to_off");
        step(0, 1, 5, 1, "to_raise");

        // Illegal NS trapping and sticky error
        step(0, 1, 4, 1, "enter4");
        step(0, 1, 12, 1, "illegal");
        step(0, 1, 15, 1, "illegal_idle");
        step(0, 1, 2, 1, "recover");
        step(1, 1, 2, 1, "clr_err");

        // Saturation with timeout disabled
        step(0, 1, 6, 0, "enter6");
        for (int i = 0; i < 20; i++) step(0, 1, 6, 0, "saturate");

        // Reset wins over timeout condition and illegal NS
        step(0, 1, 5, 1, "enter5");
        for (int i = 0; i < 7; i++) step(0, 1, 5, 1, "pre_to");
        step(1, 1, 12, 1, "rst_prio");
        step(0, 1, 1, 1, "post_rst");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(63) == 0);
            e  = ($urandom_range(7) != 0);
            te = ($urandom_range(3) != 0);
            case ($urandom_range(9))
                0:       n = $urandom_range(15, MAX_STATE + 1);
                1, 2, 3: n = $urandom_range(MAX_STATE);
                default: n = m_cs;
            endcase
            step(r, e, n, te, "rand");
        end

        drive_done = 1;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
